// File: rtl/change_dispenser_if.sv
// Signal bundle between the vend controller / payout hardware and change_dispenser.
// CHG_AUDIT_EN adds the audit counters paid_total and coin_cnt.
interface change_dispenser_if;
  logic       disp_req;
  logic [3:0] Change;
  logic       Choco;
  logic       choco_ack;
  logic       coin_ack;
  logic       fault_clr;
  logic       choco_rel;
  logic       eject_10;
  logic       eject_05;
  logic       eject_02;
  logic       eject_01;
  logic       busy;
  logic       done;
  logic       fault;
  logic [2:0] state_dbg;
`ifdef CHG_AUDIT_EN
  logic [11:0] paid_total;
  logic [7:0]  coin_cnt;
`endif

  // Handshake: a request (choco_rel / eject_*) stays high until its ack is
  // sampled high on a rising clk edge, then drops on the following cycle.
  modport master (
    output disp_req, Change, Choco, choco_ack, coin_ack, fault_clr,
    input  choco_rel, eject_10, eject_05, eject_02, eject_01,
    input  busy, done, fault, state_dbg
`ifdef CHG_AUDIT_EN
    , input paid_total, coin_cnt
`endif
  );

  modport slave (
    input  disp_req, Change, Choco, choco_ack, coin_ack, fault_clr,
    output choco_rel, eject_10, eject_05, eject_02, eject_01,
    output busy, done, fault, state_dbg
`ifdef CHG_AUDIT_EN
    , output paid_total, coin_cnt
`endif
  );
endinterface

// File: rtl/change_dispenser.sv
// Releases one chocolate and pays change greedily (10/5/2/1 Rs), one coin per ack.
// Optional macro CHG_AUDIT_EN enables paid_total / coin_cnt audit counters.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave dif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHOCO = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_EJECT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT);

  logic [2:0]      state;
  logic [3:0]      bal;
  logic [3:0]      ej;        // one-hot {10, 5, 2, 1}
  logic            choco_rel_q;
  logic [TO_W-1:0] timer;
  logic [3:0]      coin_val;
  logic [3:0]      sel_ej;

  always_comb begin
    coin_val = 4'd0;
    if (ej[3])      coin_val = 4'd10;
    else if (ej[2]) coin_val = 4'd5;
    else if (ej[1]) coin_val = 4'd2;
    else if (ej[0]) coin_val = 4'd1;
  end

  // Largest coin not exceeding the balance, so bal - coin never underflows.
  always_comb begin
    sel_ej = 4'b0000;
    if (bal >= 4'd10)     sel_ej = 4'b1000;
    else if (bal >= 4'd5) sel_ej = 4'b0100;
    else if (bal >= 4'd2) sel_ej = 4'b0010;
    else if (bal != 4'd0) sel_ej = 4'b0001;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      bal         <= 4'd0;
      ej          <= 4'b0000;
      choco_rel_q <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dif.disp_req) begin
            bal <= dif.Change;
            if (dif.Choco) begin
              state       <= S_CHOCO;
              choco_rel_q <= 1'b1;
              timer       <= '0;
            end else begin
              state <= S_SEL;
            end
          end
        end
        S_CHOCO: begin
          if (dif.choco_ack) begin
            choco_rel_q <= 1'b0;
            state       <= S_SEL;
          end else if (timer == TO_LIM) begin
            choco_rel_q <= 1'b0;
            state       <= S_FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SEL: begin
          if (bal == 4'd0) begin
            state <= S_DONE;
          end else begin
            ej    <= sel_ej;
            timer <= '0;
            state <= S_EJECT;
          end
        end
        S_EJECT: begin
          // An ack in the expiry cycle still counts as a successful payout.
          if (dif.coin_ack) begin
            bal   <= bal - coin_val;
            ej    <= 4'b0000;
            state <= S_SEL;
          end else if (timer == TO_LIM) begin
            ej    <= 4'b0000;
            state <= S_FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_FAULT: begin
          if (dif.fault_clr) begin
            bal   <= 4'd0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CHG_AUDIT_EN
  logic [11:0] paid_total_q;
  logic [7:0]  coin_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      paid_total_q <= 12'd0;
      coin_cnt_q   <= 8'd0;
    end else if (state == S_EJECT && dif.coin_ack) begin
      paid_total_q <= paid_total_q + {8'd0, coin_val};
      if (coin_cnt_q != 8'hFF) coin_cnt_q <= coin_cnt_q + 8'd1;
    end
  end

  assign dif.paid_total = paid_total_q;
  assign dif.coin_cnt   = coin_cnt_q;
`endif

  assign dif.choco_rel = choco_rel_q;
  assign dif.eject_10  = ej[3];
  assign dif.eject_05  = ej[2];
  assign dif.eject_02  = ej[1];
  assign dif.eject_01  = ej[0];
  assign dif.busy      = (state != S_IDLE);
  assign dif.done      = (state == S_DONE);
  assign dif.fault     = (state == S_FAULT);
  assign dif.state_dbg = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy-payout reference model, randomized
// ack delays and spurious acks, timeout, async reset and busy-ignore scenarios.
module tb_change_dispenser;
  localparam int ACK_TIMEOUT = 8;
  localparam int TO_W        = 8;

  localparam logic [7:0] EV_CHOCO = 8'h80;
  localparam logic [7:0] EV_DONE  = 8'hD0;
  localparam logic [7:0] EV_FAULT = 8'hF0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  change_dispenser_if dif ();

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         len_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         fixed_delay = -1;
  bit         hold_ack = 1'b0;
  bit         noise_en = 1'b0;
  int         paid_model = 0;
  int         cnt_model = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_evt(input logic [7:0] act);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got 0x%0h, expected none (t=%0t)", act, $time);
    end else begin
      check("event", int'(act), int'(exp_q.pop_front()));
    end
  endtask

  // Reference: greedy change with the coin set {10,5,2,1}.
  function automatic void push_coins(input int amt);
    int coins[4] = '{10, 5, 2, 1};
    int rem = amt;
    foreach (coins[k]) begin
      while (rem >= coins[k]) begin
        exp_q.push_back(8'(coins[k]));
        rem -= coins[k];
        paid_model += coins[k];
        if (cnt_model < 255) cnt_model++;
      end
    end
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (dif.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dif.busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic txn(input logic [3:0] chg, input logic ch, input bit poke);
    if (ch) exp_q.push_back(EV_CHOCO);
    push_coins(int'(chg));
    exp_q.push_back(EV_DONE);
    @(negedge clk);
    dif.disp_req = 1'b1;
    dif.Change   = chg;
    dif.Choco    = ch;
    @(negedge clk);
    if (poke) begin
      dif.Change = chg ^ 4'(($urandom_range(1, 15)));
      dif.Choco  = ~ch;
      @(negedge clk);
    end
    dif.disp_req = 1'b0;
    dif.Change   = 4'($urandom_range(0, 15));
    dif.Choco    = 1'($urandom_range(0, 1));
    wait_idle(300, "txn");
  endtask

  // Motor/hopper model: acks each request after a chosen delay.
  initial begin : responder
    logic r_now, r_prev, r_wait;
    int   r_cnt, r_tgt;
    r_prev = 1'b0; r_wait = 1'b0; r_cnt = 0; r_tgt = 0;
    dif.choco_ack = 1'b0;
    dif.coin_ack  = 1'b0;
    forever begin
      @(negedge clk);
      dif.choco_ack = 1'b0;
      dif.coin_ack  = 1'b0;
      r_now = dif.choco_rel | dif.eject_10 | dif.eject_05 | dif.eject_02 | dif.eject_01;
      if (!rst) begin
        r_prev = 1'b0;
        r_wait = 1'b0;
      end else begin
        if (r_now && !r_prev) begin
          r_wait = 1'b1;
          r_cnt  = 0;
          r_tgt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, ACK_TIMEOUT));
          len_q.push_back(hold_ack ? ACK_TIMEOUT + 1 : r_tgt + 1);
        end
        if (r_now && r_wait) begin
          if (!hold_ack && r_cnt == r_tgt) begin
            if (dif.choco_rel) dif.choco_ack = 1'b1;
            else               dif.coin_ack  = 1'b1;
            r_wait = 1'b0;
          end else begin
            r_cnt++;
          end
        end else if (!r_now && noise_en && $urandom_range(0, 3) == 0) begin
          dif.choco_ack = 1'($urandom_range(0, 1));
          dif.coin_ack  = 1'($urandom_range(0, 1));
        end
        r_prev = r_now;
      end
    end
  end

  // Monitor: request windows, events, mutual exclusion of requests.
  initial begin : monitor
    logic [4:0] m_cur, m_prev;
    logic       m_fprev;
    int         m_len;
    m_prev = '0; m_fprev = 1'b0; m_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_prev  = '0;
        m_fprev = 1'b0;
        m_len   = 0;
      end else begin
        m_cur = {dif.choco_rel, dif.eject_10, dif.eject_05, dif.eject_02, dif.eject_01};
        if (m_cur != 5'd0) begin
          check("one_request", $countones(m_cur), 1);
          m_len++;
        end else if (m_prev != 5'd0) begin
          if (len_q.size() == 0) check("req_len_unplanned", m_len, 0);
          else                   check("req_len", m_len, len_q.pop_front());
          m_len = 0;
        end
        if (m_cur[4] && !m_prev[4]) expect_evt(EV_CHOCO);
        if (m_cur[3] && !m_prev[3]) expect_evt(8'd10);
        if (m_cur[2] && !m_prev[2]) expect_evt(8'd5);
        if (m_cur[1] && !m_prev[1]) expect_evt(8'd2);
        if (m_cur[0] && !m_prev[0]) expect_evt(8'd1);
        if (dif.done) expect_evt(EV_DONE);
        if (dif.fault && !m_fprev) expect_evt(EV_FAULT);
        m_prev  = m_cur;
        m_fprev = dif.fault;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_choco_rel"}, int'(dif.choco_rel), 0);
    check({name, "_ejects"}, int'({dif.eject_10, dif.eject_05, dif.eject_02, dif.eject_01}), 0);
    check({name, "_busy"}, int'(dif.busy), 0);
    check({name, "_done"}, int'(dif.done), 0);
    check({name, "_fault"}, int'(dif.fault), 0);
`ifdef CHG_AUDIT_EN
    check({name, "_paid_total"}, int'(dif.paid_total), 0);
    check({name, "_coin_cnt"}, int'(dif.coin_cnt), 0);
`endif
  endtask

  initial begin : main
    int n;
    dif.disp_req  = 1'b0;
    dif.Change    = 4'd0;
    dif.Choco     = 1'b0;
    dif.fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Empty vend: done two cycles after the request.
    exp_q.push_back(EV_DONE);
    @(negedge clk);
    dif.disp_req = 1'b1;
    @(negedge clk);
    dif.disp_req = 1'b0;
    check("empty_done_early", int'(dif.done), 0);
    @(negedge clk);
    check("empty_done_pulse", int'(dif.done), 1);
    @(negedge clk);
    check("empty_busy_after", int'(dif.busy), 0);

    // Chocolate only, ack 3 cycles after release rises -> 4-cycle window.
    fixed_delay = 3;
    txn(4'd0, 1'b1, 1'b0);
    check("choco_only_busy", int'(dif.busy), 0);

    fixed_delay = 2;
    txn(4'd14, 1'b0, 1'b0);
`ifdef CHG_AUDIT_EN
    check("audit_paid_14", int'(dif.paid_total), 14);
    check("audit_cnt_14", int'(dif.coin_cnt), 3);
`endif

    fixed_delay = -1;
    txn(4'd15, 1'b1, 1'b0);
    fixed_delay = ACK_TIMEOUT;
    txn(4'd9, 1'b0, 1'b0);

    // Timeout: no ack ever arrives.
    fixed_delay = -1;
    hold_ack = 1'b1;
    exp_q.push_back(8'd1);
    exp_q.push_back(EV_FAULT);
    @(negedge clk);
    dif.disp_req = 1'b1;
    dif.Change   = 4'd1;
    dif.Choco    = 1'b0;
    @(negedge clk);
    dif.disp_req = 1'b0;
    n = 0;
    while (!dif.fault && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fault_raised", int'(dif.fault), 1);
    check("fault_no_done", int'(dif.done), 0);
    dif.disp_req = 1'b1;
    dif.Change   = 4'd5;
    @(negedge clk);
    dif.disp_req = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_ignores_req", int'(dif.fault), 1);
    check("fault_busy", int'(dif.busy), 1);
    dif.fault_clr = 1'b1;
    @(negedge clk);
    dif.fault_clr = 1'b0;
    check("fault_cleared", int'(dif.fault), 0);
    check("fault_clr_idle", int'(dif.busy), 0);
    hold_ack = 1'b0;
    txn(4'd7, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an Rs 9 payout.
    fixed_delay = 4;
    push_coins(9);
    @(negedge clk);
    dif.disp_req = 1'b1;
    dif.Change   = 4'd9;
    dif.Choco    = 1'b0;
    @(negedge clk);
    dif.disp_req = 1'b0;
    n = 0;
    while (!(dif.eject_05 | dif.eject_02) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_mid_eject_seen", int'(dif.eject_05 | dif.eject_02), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    exp_q.delete();
    len_q.delete();
    paid_model = 0;
    cnt_model  = 0;
    @(negedge clk);
    rst = 1'b1;
    fixed_delay = -1;
    txn(4'd3, 1'b0, 1'b0);

    // Request while busy is dropped.
    txn(4'd13, 1'b1, 1'b1);
    txn(4'd0, 1'b0, 1'b1);

    noise_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
    noise_en = 1'b0;

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("len_q_drained", len_q.size(), 0);
`ifdef CHG_AUDIT_EN
    check("audit_paid_final", int'(dif.paid_total), paid_model % 4096);
    check("audit_cnt_final", int'(dif.coin_cnt), cnt_model);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
